// File: rtl/issue_scoreboard.sv
// Issue controller between ID and EX: load-writeback scoreboard, RAW/WAW stall, FENCE drain, redirect flush.
// Latency: id_ready/issue/flush are combinational in the same cycle; scoreboard and counter update at the clock edge.
// Backpressure: id_ready drops on hazard, full load tracker, pending fence, DRAIN/REDIRECT or redirect; optional SB_BYPASS_EN lets a same-cycle lsu_done release the stall.
module issue_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int MAX_LOADS = 4,
  localparam int LW       = $clog2(MAX_LOADS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [4:0]          id_rs1,
  input  logic [4:0]          id_rs2,
  input  logic [4:0]          id_rd,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic                id_writes_rd,
  input  logic                id_is_load,
  input  logic                id_is_fence,
  output logic                id_ready,
  output logic                issue,
  input  logic                lsu_done,
  input  logic [4:0]          lsu_rd,
  input  logic                ex_redirect,
  output logic                flush_if,
  output logic                flush_id,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [LW-1:0]       loads_out,
  output logic                sb_err
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, REDIRECT = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [LW-1:0]       loads_q, loads_d;
  logic                sb_err_q, sb_err_d;

  logic [NUM_REGS-1:0] busy_eff;
  logic [LW-1:0]       loads_eff;
  logic                haz1, haz2, waw, full, fence_wait, err_ev;

  // View of the scoreboard used for hazard checks (optionally including a same-cycle completion)
  always_comb begin
    busy_eff  = busy_q;
    loads_eff = loads_q;
`ifdef SB_BYPASS_EN
    if (lsu_done) begin
      busy_eff[lsu_rd] = 1'b0;
      if (loads_q != '0) loads_eff = loads_q - LW'(1);
    end
`endif
  end

  // Hazard terms, ready/issue and redirect flushes
  always_comb begin
    haz1       = id_uses_rs1 && (id_rs1 != 5'd0) && busy_eff[id_rs1];
    haz2       = id_uses_rs2 && (id_rs2 != 5'd0) && busy_eff[id_rs2];
    waw        = id_writes_rd && (id_rd != 5'd0) && busy_eff[id_rd];
    full       = id_is_load && (loads_eff == LW'(MAX_LOADS));
    fence_wait = id_is_fence && (loads_eff != '0);
    id_ready   = !rst && (state_q == RUN) && !ex_redirect &&
                 !(haz1 || haz2 || waw || full || fence_wait);
    issue      = id_valid && id_ready;
    flush_if   = ex_redirect;
    flush_id   = ex_redirect;
  end

  // Scoreboard, in-flight counter and sticky protocol error; a set beats a clear on the same register
  always_comb begin
    busy_d   = busy_q;
    loads_d  = loads_q;
    err_ev   = lsu_done && ((loads_q == '0) || ((lsu_rd != 5'd0) && !busy_q[lsu_rd]));
    sb_err_d = sb_err_q || err_ev;
    // A completion with nothing in flight is ignored apart from raising the error.
    if (lsu_done && (loads_q != '0)) begin
      busy_d[lsu_rd] = 1'b0;
      loads_d        = loads_d - LW'(1);
    end
    if (issue && id_is_load) begin
      loads_d = loads_d + LW'(1);
      if (id_writes_rd && (id_rd != 5'd0)) busy_d[id_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Next-state logic: redirect overrides everything, drain waits for the counter to empty
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (id_valid && fence_wait) state_d = DRAIN;
      DRAIN:    if (loads_d == '0) state_d = RUN;
      REDIRECT: state_d = RUN;
      default:  state_d = RUN;
    endcase
    if (ex_redirect) state_d = REDIRECT;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      busy_q   <= '0;
      loads_q  <= '0;
      sb_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      loads_q  <= loads_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign busy_vec  = busy_q;
  assign loads_out = loads_q;
  assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_writes_rd, id_is_load, id_is_fence;
  logic [4:0]  id_rs1, id_rs2, id_rd, lsu_rd;
  logic        lsu_done, ex_redirect;
  logic        id_ready, issue, flush_if, flush_id, sb_err;
  logic [31:0] busy_vec;
  logic [2:0]  loads_out;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  issue_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_writes_rd(id_writes_rd),
    .id_is_load(id_is_load), .id_is_fence(id_is_fence), .id_ready(id_ready), .issue(issue),
    .lsu_done(lsu_done), .lsu_rd(lsu_rd), .ex_redirect(ex_redirect), .flush_if(flush_if),
    .flush_id(flush_id), .busy_vec(busy_vec), .loads_out(loads_out), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  // Reference model: set of pending registers, number of loads in flight, mode.
  typedef enum {M_RUN, M_DRAIN, M_REDIR} mode_e;
  bit    m_busy[32];
  int    m_loads;
  bit    m_err;
  mode_e m_mode;

  function automatic int eff_loads();
    int l = m_loads;
    if (BYP && lsu_done && l > 0) l--;
    return l;
  endfunction

  function automatic bit model_ready();
    bit b[32];
    int l;
    b = m_busy;
    l = eff_loads();
    if (BYP && lsu_done) b[lsu_rd] = 1'b0;
    if (rst || ex_redirect || m_mode != M_RUN) return 1'b0;
    if (id_uses_rs1 && id_rs1 != 0 && b[id_rs1]) return 1'b0;
    if (id_uses_rs2 && id_rs2 != 0 && b[id_rs2]) return 1'b0;
    if (id_writes_rd && id_rd != 0 && b[id_rd]) return 1'b0;
    if (id_is_load && l == 4) return 1'b0;
    if (id_is_fence && l != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_vec();
    logic [31:0] v = '0;
    for (int i = 1; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_edge();
    bit rdy, ev, fw;
    rdy = model_ready();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_loads = 0; m_err = 1'b0; m_mode = M_RUN;
      return;
    end
    ev = lsu_done && (m_loads == 0 || (lsu_rd != 0 && !m_busy[lsu_rd]));
    fw = id_is_fence && eff_loads() != 0;
    if (lsu_done && m_loads > 0) begin
      m_busy[lsu_rd] = 1'b0;
      m_loads--;
    end
    if (id_valid && rdy && id_is_load) begin
      m_loads++;
      if (id_writes_rd && id_rd != 0) m_busy[id_rd] = 1'b1;
    end
    if (ev) m_err = 1'b1;
    if (ex_redirect) m_mode = M_REDIR;
    else if (m_mode == M_RUN && id_valid && fw) m_mode = M_DRAIN;
    else if (m_mode == M_DRAIN && m_loads == 0) m_mode = M_RUN;
    else if (m_mode == M_REDIR) m_mode = M_RUN;
  endtask

  task automatic advance();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_writes_rd = 0; id_is_load = 0; id_is_fence = 0; lsu_done = 0; lsu_rd = 0; ex_redirect = 0;
  endtask

  task automatic instr(input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit w, input bit ld, input bit fn);
    id_valid = 1; id_rs1 = 5'(rs1); id_uses_rs1 = u1; id_rs2 = 5'(rs2); id_uses_rs2 = u2;
    id_rd = 5'(rd); id_writes_rd = w; id_is_load = ld; id_is_fence = fn;
  endtask

  task automatic test_reset();
    rst = 1; clr_in();
    advance(); advance();
    instr(1, 1, 2, 1, 3, 1, 0, 0);
    @(negedge clk);
    n_chk++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", id_ready); end
    n_chk++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", busy_vec); end
    n_chk++; if (loads_out !== 3'd0) begin n_fail++; $display("FAIL reset_loads: got %0d expected 0", loads_out); end
    n_chk++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", sb_err); end
    n_chk++; if (flush_if !== 1'b0 || flush_id !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b%b expected 00", flush_if, flush_id); end
    advance();
    rst = 0; clr_in();
  endtask

  task automatic test_load_use();
    instr(2, 1, 0, 0, 5, 1, 1, 0);               // LW x5, 0(x2)
    @(negedge clk);
    n_chk++; if (issue !== 1'b1) begin n_fail++; $display("FAIL lu_load_issue: got %b expected 1", issue); end
    advance();
    instr(5, 1, 1, 1, 6, 1, 0, 0);               // ADD x6, x5, x1
    @(negedge clk);
    n_chk++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL lu_stall: got %b expected 0", id_ready); end
    n_chk++; if (busy_vec !== 32'h20) begin n_fail++; $display("FAIL lu_busy: got %h expected 20", busy_vec); end
    n_chk++; if (loads_out !== 3'd1) begin n_fail++; $display("FAIL lu_loads: got %0d expected 1", loads_out); end
    advance();
    lsu_done = 1; lsu_rd = 5;
    @(negedge clk);
    n_chk++; if (issue !== BYP) begin n_fail++; $display("FAIL lu_done_cycle_issue: got %b expected %b", issue, BYP); end
    advance();
    lsu_done = 0;
    if (!BYP) begin
      @(negedge clk);
      n_chk++; if (issue !== 1'b1) begin n_fail++; $display("FAIL lu_next_cycle_issue: got %b expected 1", issue); end
      advance();
    end
    clr_in();
    @(negedge clk);
    n_chk++; if (busy_vec !== 32'h0 || loads_out !== 3'd0) begin n_fail++; $display("FAIL lu_final: got %h/%0d expected 0/0", busy_vec, loads_out); end
    advance();
  endtask

  task automatic test_full();
    for (int r = 1; r <= 4; r++) begin
      instr(0, 0, 0, 0, r, 1, 1, 0);
      @(negedge clk);
      n_chk++; if (issue !== 1'b1) begin n_fail++; $display("FAIL full_fill_issue: got %b expected 1 (rd %0d)", issue, r); end
      advance();
    end
    instr(0, 0, 0, 0, 7, 1, 1, 0);
    @(negedge clk);
    n_chk++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL full_stall: got %b expected 0", id_ready); end
    n_chk++; if (loads_out !== 3'd4) begin n_fail++; $display("FAIL full_loads: got %0d expected 4", loads_out); end
    advance();
    lsu_done = 1; lsu_rd = 1;
    @(negedge clk);
    n_chk++; if (issue !== BYP) begin n_fail++; $display("FAIL full_done_issue: got %b expected %b", issue, BYP); end
    advance();
    lsu_done = 0;
    if (!BYP) begin
      @(negedge clk);
      n_chk++; if (loads_out !== 3'd3) begin n_fail++; $display("FAIL full_loads_after: got %0d expected 3", loads_out); end
      n_chk++; if (issue !== 1'b1) begin n_fail++; $display("FAIL full_fifth_issue: got %b expected 1", issue); end
      advance();
    end
    clr_in();
    @(negedge clk);
    n_chk++; if (busy_vec !== 32'h9C) begin n_fail++; $display("FAIL full_busy: got %h expected 9c", busy_vec); end
    foreach (m_busy[i]) if (m_busy[i]) begin
      lsu_done = 1; lsu_rd = 5'(i);
      advance();
    end
    clr_in();
    @(negedge clk);
    n_chk++; if (loads_out !== 3'd0 || sb_err !== 1'b0) begin n_fail++; $display("FAIL full_retire: got %0d/%b expected 0/0", loads_out, sb_err); end
    advance();
  endtask

  task automatic test_fence();
    instr(0, 0, 0, 0, 8, 1, 1, 0); advance();
    instr(0, 0, 0, 0, 9, 1, 1, 0); advance();
    instr(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    n_chk++; if (id_ready !== 1'b0 || loads_out !== 3'd2) begin n_fail++; $display("FAIL fence_wait: got %b/%0d expected 0/2", id_ready, loads_out); end
    advance();
    lsu_done = 1; lsu_rd = 8;
    @(negedge clk);
    n_chk++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL fence_drain1: got %b expected 0", id_ready); end
    advance();
    lsu_rd = 9;
    @(negedge clk);
    n_chk++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL fence_drain2: got %b expected 0", id_ready); end
    advance();
    lsu_done = 0;
    @(negedge clk);
    n_chk++; if (loads_out !== 3'd0) begin n_fail++; $display("FAIL fence_loads: got %0d expected 0", loads_out); end
    n_chk++; if (issue !== 1'b1) begin n_fail++; $display("FAIL fence_issue: got %b expected 1", issue); end
    advance();
    clr_in();
  endtask

  task automatic test_redirect();
    instr(0, 0, 0, 0, 10, 1, 1, 0); advance();
    instr(10, 1, 0, 1, 11, 1, 0, 0);             // ADD x11, x10, x0 (stalled)
    ex_redirect = 1;
    @(negedge clk);
    n_chk++; if (flush_if !== 1'b1 || flush_id !== 1'b1) begin n_fail++; $display("FAIL redir_flush: got %b%b expected 11", flush_if, flush_id); end
    n_chk++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL redir_ready0: got %b expected 0", id_ready); end
    advance();
    ex_redirect = 0; lsu_done = 1; lsu_rd = 10;
    @(negedge clk);
    n_chk++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL redir_ready1: got %b expected 0", id_ready); end
    n_chk++; if (flush_if !== 1'b0) begin n_fail++; $display("FAIL redir_flush_off: got %b expected 0", flush_if); end
    n_chk++; if (busy_vec !== 32'h400) begin n_fail++; $display("FAIL redir_busy: got %h expected 400", busy_vec); end
    advance();
    lsu_done = 0;
    @(negedge clk);
    n_chk++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL redir_ready2: got %b expected 1", id_ready); end
    advance();
    clr_in();
  endtask

  task automatic test_x0();
    instr(0, 0, 0, 0, 0, 1, 1, 0);               // load to x0
    @(negedge clk);
    n_chk++; if (issue !== 1'b1) begin n_fail++; $display("FAIL x0_issue: got %b expected 1", issue); end
    advance();
    instr(0, 1, 0, 1, 12, 1, 0, 0);
    @(negedge clk);
    n_chk++; if (busy_vec !== 32'h0 || loads_out !== 3'd1) begin n_fail++; $display("FAIL x0_state: got %h/%0d expected 0/1", busy_vec, loads_out); end
    n_chk++; if (issue !== 1'b1) begin n_fail++; $display("FAIL x0_dep_issue: got %b expected 1", issue); end
    advance();
    clr_in(); lsu_done = 1; lsu_rd = 0;
    advance();
    clr_in();
    @(negedge clk);
    n_chk++; if (loads_out !== 3'd0 || sb_err !== 1'b0) begin n_fail++; $display("FAIL x0_retire: got %0d/%b expected 0/0", loads_out, sb_err); end
    advance();
  endtask

  task automatic test_err();
    lsu_done = 1; lsu_rd = 3;
    advance();
    clr_in();
    @(negedge clk);
    n_chk++; if (sb_err !== 1'b1 || loads_out !== 3'd0) begin n_fail++; $display("FAIL err_set: got %b/%0d expected 1/0", sb_err, loads_out); end
    advance();
    instr(0, 0, 0, 0, 12, 1, 1, 0); advance();
    clr_in();
    @(negedge clk);
    n_chk++; if (sb_err !== 1'b1 || busy_vec !== 32'h1000) begin n_fail++; $display("FAIL err_hold: got %b/%h expected 1/1000", sb_err, busy_vec); end
    rst = 1;
    advance();
    rst = 0;
    @(negedge clk);
    n_chk++; if (sb_err !== 1'b0 || busy_vec !== 32'h0 || loads_out !== 3'd0) begin
      n_fail++; $display("FAIL err_rst: got %b/%h/%0d expected 0/0/0", sb_err, busy_vec, loads_out); end
    advance();
  endtask

  task automatic test_random();
    int q[$];
    for (int c = 0; c < 400; c++) begin
      clr_in();
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
      id_uses_rs1 = $urandom_range(0, 1); id_uses_rs2 = $urandom_range(0, 1);
      id_writes_rd = $urandom_range(0, 1);
      id_is_load = ($urandom_range(0, 2) == 0);
      id_is_fence = !id_is_load && ($urandom_range(0, 9) == 0);
      ex_redirect = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 149) == 0);
      q.delete();
      foreach (m_busy[i]) if (m_busy[i]) q.push_back(i);
      if (m_loads > 0 && $urandom_range(0, 2) == 0) begin
        lsu_done = 1;
        lsu_rd = (q.size() > 0) ? 5'(q[$urandom_range(0, q.size() - 1)]) : 5'd0;
      end else if ($urandom_range(0, 99) == 0) begin
        lsu_done = 1; lsu_rd = 5'($urandom_range(0, 7));
      end
      @(negedge clk);
      n_chk++; if (id_ready !== model_ready()) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, id_ready, model_ready()); end
      n_chk++; if (issue !== (id_valid && model_ready())) begin n_fail++; $display("FAIL rnd_issue c%0d: got %b expected %b", c, issue, id_valid && model_ready()); end
      n_chk++; if (flush_if !== ex_redirect || flush_id !== ex_redirect) begin n_fail++; $display("FAIL rnd_flush c%0d: got %b%b expected %b", c, flush_if, flush_id, ex_redirect); end
      n_chk++; if (busy_vec !== model_vec()) begin n_fail++; $display("FAIL rnd_busy c%0d: got %h expected %h", c, busy_vec, model_vec()); end
      n_chk++; if (loads_out !== 3'(m_loads)) begin n_fail++; $display("FAIL rnd_loads c%0d: got %0d expected %0d", c, loads_out, m_loads); end
      n_chk++; if (sb_err !== m_err) begin n_fail++; $display("FAIL rnd_err c%0d: got %b expected %b", c, sb_err, m_err); end
      advance();
    end
    clr_in(); rst = 0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_full();
    test_fence();
    test_redirect();
    test_x0();
    test_err();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
